// File: rtl/vec_index_counter.sv
// Bounded, restartable element/address sequencer: a start loads length, base and
// stride, and each enable steps the element index and address until the last element.
module vec_index_counter #(
    parameter int N      = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [N-1:0]      length,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] stride,
    input  logic              enable,
    output logic              busy,
    output logic [N-1:0]      count,
    output logic [ADDR_W-1:0] addr,
    output logic              last,
    output logic              done
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state_r, state_s;
    logic [N-1:0]        len_r, len_s;
    logic [ADDR_W-1:0]   stride_r, stride_s;
    logic [N-1:0]        count_r, count_s;
    logic [ADDR_W-1:0]   addr_r, addr_s;
    logic                done_r, done_s;
    logic                last_s;

    // Final element flag; count never passes len_r-1, so the compare cannot alias.
    always_comb begin
        last_s = (state_r == RUN) && (count_r == (len_r - N'(1)));
    end

    // Next-state logic: start is honoured only in IDLE, enable only in RUN.
    always_comb begin
        state_s  = state_r;
        len_s    = len_r;
        stride_s = stride_r;
        count_s  = count_r;
        addr_s   = addr_r;
        done_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (length != {N{1'b0}}) begin
                        state_s  = RUN;
                        len_s    = length;
                        stride_s = stride;
                        count_s  = {N{1'b0}};
                        addr_s   = base;
                    end else begin
                        done_s   = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (enable) begin
                    if (last_s) begin
                        state_s = IDLE;
                        done_s  = 1'b1;
                    end else begin
                        count_s = count_r + N'(1);
                        addr_s  = addr_r + stride_r;
                    end
                end else begin
                    state_s = RUN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any run without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            len_r    <= {N{1'b0}};
            stride_r <= {ADDR_W{1'b0}};
            count_r  <= {N{1'b0}};
            addr_r   <= {ADDR_W{1'b0}};
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            len_r    <= len_s;
            stride_r <= stride_s;
            count_r  <= count_s;
            addr_r   <= addr_s;
            done_r   <= done_s;
        end
    end

    assign busy  = (state_r == RUN);
    assign count = count_r;
    assign addr  = addr_r;
    assign last  = last_s;
    assign done  = done_r;

endmodule

// File: tb/tb_vec_index_counter.sv
// Directed bench for vec_index_counter with hand-computed expected sequences.
module tb_vec_index_counter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  length;
    logic [15:0] base;
    logic [15:0] stride;
    logic        enable;
    logic        busy;
    logic [7:0]  count;
    logic [15:0] addr;
    logic        last;
    logic        done;

    int errors = 0;
    int checks = 0;

    vec_index_counter #(.N(8), .ADDR_W(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .length (length),
        .base   (base),
        .stride (stride),
        .enable (enable),
        .busy   (busy),
        .count  (count),
        .addr   (addr),
        .last   (last),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [7:0] l, input logic [15:0] b, input logic [15:0] s);
        start  = 1'b1;
        length = l;
        base   = b;
        stride = s;
        step();
        start  = 1'b0;
    endtask

    logic [6:0] en_pat;
    int         exp_cnt;
    logic       exp_done;

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        length = 8'd0;
        base   = 16'd0;
        stride = 16'd0;
        enable = 1'b0;
        #12;
        chk("rst_busy", busy, 1'b0);
        chk("rst_count", count, 8'd0);
        chk("rst_addr", addr, 16'd0);
        chk("rst_last", last, 1'b0);
        chk("rst_done", done, 1'b0);
        step();
        rst_n = 1'b1;

        // Run 1: length 4, enable held high, enable also high during start
        enable = 1'b1;
        launch(8'd4, 16'h0100, 16'd4);
        for (int i = 0; i < 4; i++) begin
            chk("r1_busy", busy, 1'b1);
            chk("r1_count", count, i);
            chk("r1_addr", addr, 16'h0100 + 16'(4 * i));
            chk("r1_last", last, (i == 3));
            chk("r1_done", done, 1'b0);
            step();
        end
        chk("r1_done_pulse", done, 1'b1);
        chk("r1_end_busy", busy, 1'b0);
        chk("r1_end_addr", addr, 16'h010C);
        chk("r1_end_count", count, 8'd3);
        chk("r1_end_last", last, 1'b0);
        step();
        chk("r1_done_clear", done, 1'b0);

        // Run 2: enable toggling 1,0,0,1,1,0,1
        enable = 1'b0;
        launch(8'd4, 16'h0100, 16'd4);
        chk("r2_start_addr", addr, 16'h0100);
        en_pat  = 7'b1011001;
        exp_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            enable   = en_pat[i];
            exp_done = 1'b0;
            if (en_pat[i]) begin
                if (exp_cnt == 3) exp_done = 1'b1;
                else exp_cnt++;
            end
            step();
            chk("r2_count", count, exp_cnt);
            chk("r2_addr", addr, 16'h0100 + 16'(4 * exp_cnt));
            chk("r2_done", done, exp_done);
            chk("r2_busy", busy, !exp_done);
        end
        enable = 1'b0;
        step();

        // Run 3: address wrap
        launch(8'd3, 16'hFFF8, 16'd8);
        enable = 1'b1;
        chk("wrap_a0", addr, 16'hFFF8);
        step();
        chk("wrap_a1", addr, 16'h0000);
        step();
        chk("wrap_a2", addr, 16'h0008);
        chk("wrap_last", last, 1'b1);
        step();
        chk("wrap_done", done, 1'b1);
        chk("wrap_hold", addr, 16'h0008);
        enable = 1'b0;
        step();

        // Zero length: no run, single done pulse, count/addr unchanged
        launch(8'd0, 16'h7777, 16'd1);
        chk("zl_busy", busy, 1'b0);
        chk("zl_done", done, 1'b1);
        chk("zl_addr", addr, 16'h0008);
        chk("zl_count", count, 8'd2);
        step();
        chk("zl_done_clear", done, 1'b0);
        chk("zl_busy2", busy, 1'b0);

        // Length 1: last immediately
        launch(8'd1, 16'h0040, 16'd2);
        chk("l1_busy", busy, 1'b1);
        chk("l1_last", last, 1'b1);
        chk("l1_addr", addr, 16'h0040);
        enable = 1'b1;
        step();
        chk("l1_done", done, 1'b1);
        chk("l1_busy_end", busy, 1'b0);
        enable = 1'b0;
        step();

        // Mid-run start ignored, then start in done cycle launches next run
        enable = 1'b1;
        launch(8'd4, 16'h0200, 16'd1);
        step();
        start  = 1'b1;
        length = 8'd9;
        base   = 16'h5000;
        stride = 16'd7;
        chk("mr_addr1", addr, 16'h0201);
        step();
        chk("mr_addr2", addr, 16'h0202);
        start = 1'b0;
        step();
        chk("mr_addr3", addr, 16'h0203);
        chk("mr_last", last, 1'b1);
        step();
        chk("mr_done", done, 1'b1);
        chk("mr_count", count, 8'd3);
        launch(8'd2, 16'h0300, 16'h0010);
        chk("b2b_busy", busy, 1'b1);
        chk("b2b_done_clear", done, 1'b0);
        chk("b2b_addr0", addr, 16'h0300);
        step();
        chk("b2b_addr1", addr, 16'h0310);
        chk("b2b_last", last, 1'b1);
        step();
        chk("b2b_done", done, 1'b1);
        enable = 1'b0;
        step();

        // Asynchronous reset mid-run at count 2
        enable = 1'b1;
        launch(8'd5, 16'h0400, 16'd2);
        step();
        step();
        chk("ar_pre_count", count, 8'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_busy", busy, 1'b0);
        chk("ar_count", count, 8'd0);
        chk("ar_addr", addr, 16'd0);
        chk("ar_last", last, 1'b0);
        chk("ar_done", done, 1'b0);
        step();
        step();
        chk("ar_hold_done", done, 1'b0);
        rst_n = 1'b1;
        step();
        chk("ar_post_done", done, 1'b0);
        chk("ar_post_busy", busy, 1'b0);
        launch(8'd2, 16'h0010, 16'd3);
        chk("fr_addr0", addr, 16'h0010);
        step();
        chk("fr_addr1", addr, 16'h0013);
        step();
        chk("fr_done", done, 1'b1);
        chk("fr_busy", busy, 1'b0);
        enable = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
